fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction Fetch stage of the pipelined MIPS core, directly upstream of decode_stage.
- Owns the PC register, next-PC selection (PC+4 / branch / jump) and the IF/ID pipeline register that drives instr_D and D_PCPlus4_D into decode.
- Talks to a variable-latency instruction memory over a req/ready handshake.
- Inserts NOP bubbles on redirects and memory waits; honours hazard-unit stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding driven on instr_D for a bubble (sll $0,$0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PC_src_D  input  2  from decode: bit1 = jump, bit0 = branch taken.
- PCbranch_D  input  32  branch target from decode.
- stall_FD  input  1  hazard unit: hold PC and IF/ID this cycle.
- imem_addr  output  32  instruction memory word address (byte address, [1:0]=0).
- imem_req  output  1  fetch request; addr must stay stable while req=1 and ready=0.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- imem_ready  input  1  memory completes the current request this cycle.
- instr_D  output  32  IF/ID instruction register.
- D_PCPlus4_D  output  32  IF/ID PC+4 register.
- valid_D  output  1  IF/ID holds a real instruction (0 = bubble).
- PC_F  output  32  current fetch PC (debug/trace).

Behaviour:
- Reset (sync, highest priority): PC_F=RESET_PC, state=FETCH, instr_D=NOP_INSTR, D_PCPlus4_D=0, valid_D=0, hold buffer cleared. imem_req=0 while reset=1.
- Definitions:
  - redirect = (PC_src_D!=0) & valid_D & ~stall_FD.
  - target = PC_src_D[1] ? {D_PCPlus4_D[31:28], instr_D[25:0], 2'b00} : PCbranch_D.
  - Jump wins when PC_src_D=2'b11.
- State machine: FETCH, HOLD, DRAIN.
  - FETCH: imem_req=1, imem_addr=PC_F.
  - HOLD: imem_req=0; a fetched word is buffered (buf_instr, buf_pc).
  - DRAIN: imem_req=1, imem_addr=drain_addr (old request kept stable); data returned is discarded.
- Priority per cycle: reset > redirect > stall_FD > normal.
- Redirect, from any state: IF/ID loads bubble (NOP_INSTR, valid_D=0, D_PCPlus4_D unchanged).
  - FETCH & ready: data dropped, PC_F<=target, stay FETCH.
  - FETCH & ~ready: drain_addr<=PC_F, PC_F<=target, go DRAIN.
  - HOLD: buffer dropped, PC_F<=target, go FETCH.
  - DRAIN: PC_F<=target (latest wins), stay DRAIN.
- stall_FD=1, no redirect: IF/ID and PC_F hold.
  - FETCH & ready: buf<=imem_rdata, buf_pc<=PC_F, go HOLD.
  - FETCH & ~ready, HOLD, DRAIN: no state change, except DRAIN & ready -> FETCH.
- Normal (stall_FD=0, no redirect):
  - FETCH & ready: IF/ID<={imem_rdata, PC_F+4, valid 1}, PC_F<=PC_F+4.
  - FETCH & ~ready: IF/ID<=bubble.
  - HOLD: IF/ID<={buf, buf_pc+4, valid 1}, PC_F<=buf_pc+4, go FETCH.
  - DRAIN: IF/ID<=bubble; on ready go FETCH (data discarded).
- Latency: with ready tied high, a 1-cycle-per-instruction throughput; instruction at PC appears on instr_D the cycle after imem_addr=PC.
- Taken branch/jump costs exactly one bubble (the fall-through slot), plus any drain wait.
- Arithmetic: PC+4 is 32-bit wrapping (32'hFFFF_FFFC -> 0). No alignment checking; PC_F[1:0] stays 0 given aligned targets.
- Redirect when valid_D=0 is ignored (bubbles cannot branch).

Decomposition:
- Shared package (mips_pkg): fetch state encoding (FETCH/HOLD/DRAIN), NOP constant, PC_src encoding constants (PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_J=2'b1x).
- One natural sub-module: if_id_reg (instr/PC+4/valid register with enable and synchronous clear).
- Next-PC mux and FSM stay inline.

Test Plan:
- Reset, ready tied 1, memory returns addr-tagged words -> PC_F 0,4,8,...; instr_D at cycle n+1 = word(4n); valid_D=0 only in the first cycle after reset.
- Branch at 0x10 (PC_src_D=01, PCbranch_D=0x40) -> next instr_D is NOP with valid_D=0, then word(0x40); word(0x14) never reaches decode.
- Jump instr 0x08000010 with D_PCPlus4_D=0x1000_0004 -> PC_F=0x1000_0040; PC_src_D=11 with PCbranch_D=0x80 also goes to 0x1000_0040.
- ready asserted every 3rd cycle, stall_FD=0 -> two bubbles between real instructions; imem_addr stable while req&~ready.
- stall_FD=1 for 4 cycles while ready=1 -> FSM enters HOLD, imem_req=0, instr_D/PC_F frozen; on release the buffered word issues with correct PC+4, with no skip or duplicate.
- Redirect to 0x200 while memory waiting on 0x30 (ready low 3 cycles) -> DRAIN holds imem_addr=0x30, data discarded, next request addr=0x200; reset asserted mid-DRAIN -> PC_F=RESET_PC, valid_D=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the fetch-stage state encoding, the bubble instruction encoding,
// the PC_src encodings coming back from decode, and the jump-target helper.
package mips_pkg;

   // Fetch controller states:
   //   FETCH - a request for PC_F is outstanding on the instruction memory
   //   HOLD  - a word arrived during a stall and is parked in the buffer
   //   DRAIN - an abandoned request is being completed; its data is dropped
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

   // PC_src_D encodings: bit1 selects jump regardless of bit0
   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;

   // J-type target: upper nibble of PC+4, 26-bit index, word aligned
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [31:0] instr);
      return {pc_plus4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   load               - capture instr_in / pc_plus4_in as a real instruction
//   bubble             - replace the instruction with a NOP, keep pc_plus4
//   instr_in, pc_plus4_in - next instruction word and its PC+4
//   instr, pc_plus4, valid - registered outputs toward decode
// When neither load nor bubble is asserted the register holds (stall).
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = MIPS_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_plus4_in,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   // A bubble leaves pc_plus4 untouched so a later jump-target computation
   // never sees a value invented for the bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr    <= NOP_INSTR;
         pc_plus4 <= 32'h0000_0000;
         valid    <= 1'b0;
      end else if (bubble) begin
         instr    <= NOP_INSTR;
         valid    <= 1'b0;
      end else if (load) begin
         instr    <= instr_in;
         pc_plus4 <= pc_plus4_in;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction Fetch stage of the pipelined MIPS core.
// Owns the PC, next-PC selection and the IF/ID register, and talks to a
// variable-latency instruction memory through a req/ready handshake.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   PC_src_D, PCbranch_D    - redirect request and branch target from decode
//   stall_FD                - hazard-unit stall of PC and IF/ID
//   imem_addr, imem_req     - instruction memory request
//   imem_rdata, imem_ready  - instruction memory response
//   instr_D, D_PCPlus4_D, valid_D - IF/ID register contents
//   PC_F                    - current fetch PC
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PC_src_D,
   input  logic [31:0] PCbranch_D,
   input  logic        stall_FD,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instr_D,
   output logic [31:0] D_PCPlus4_D,
   output logic        valid_D,
   output logic [31:0] PC_F
);

   fetch_state_t state, state_next;
   logic [31:0]  pc_next;
   logic [31:0]  buf_instr, buf_pc, drain_addr;
   logic         buf_load, drain_load;
   logic         id_load, id_bubble;
   logic [31:0]  id_instr, id_pc4;
   logic         redirect;
   logic [31:0]  target;

   // Only a real instruction in decode may redirect, and a stalled decode
   // has not resolved its branch yet.
   assign redirect = (PC_src_D != PCSRC_SEQ) & valid_D & ~stall_FD;
   assign target   = PC_src_D[1] ? jump_target(D_PCPlus4_D, instr_D) : PCbranch_D;

   // DRAIN keeps presenting the abandoned address so the memory sees a
   // stable request until it completes.
   assign imem_req  = ~reset & (state != HOLD);
   assign imem_addr = (state == DRAIN) ? drain_addr : PC_F;

   // Next-state and datapath control; redirect beats stall beats normal flow.
   always_comb begin
      state_next = state;
      pc_next    = PC_F;
      buf_load   = 1'b0;
      drain_load = 1'b0;
      id_load    = 1'b0;
      id_bubble  = 1'b0;
      id_instr   = imem_rdata;
      id_pc4     = PC_F + 32'd4;
      if (redirect) begin
         id_bubble = 1'b1;
         pc_next   = target;
         case (state)
            FETCH: if (!imem_ready) begin
                      drain_load = 1'b1;
                      state_next = DRAIN;
                   end
            HOLD:  state_next = FETCH;
            default: state_next = state;
         endcase
      end else if (stall_FD) begin
         case (state)
            FETCH: if (imem_ready) begin
                      buf_load   = 1'b1;
                      state_next = HOLD;
                   end
            DRAIN: if (imem_ready) state_next = FETCH;
            default: state_next = state;
         endcase
      end else begin
         case (state)
            FETCH: if (imem_ready) begin
                      id_load = 1'b1;
                      pc_next = PC_F + 32'd4;
                   end else begin
                      id_bubble = 1'b1;
                   end
            HOLD: begin
                      id_load    = 1'b1;
                      id_instr   = buf_instr;
                      id_pc4     = buf_pc + 32'd4;
                      pc_next    = buf_pc + 32'd4;
                      state_next = FETCH;
                   end
            DRAIN: begin
                      id_bubble = 1'b1;
                      if (imem_ready) state_next = FETCH;
                   end
            default: state_next = FETCH;
         endcase
      end
   end

   // PC, controller state, parked word and drain address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         PC_F       <= RESET_PC;
         state      <= FETCH;
         buf_instr  <= NOP_INSTR;
         buf_pc     <= 32'h0000_0000;
         drain_addr <= 32'h0000_0000;
      end else begin
         PC_F  <= pc_next;
         state <= state_next;
         if (buf_load) begin
            buf_instr <= imem_rdata;
            buf_pc    <= PC_F;
         end
         if (drain_load) drain_addr <= PC_F;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk         (clk),
      .reset       (reset),
      .load        (id_load),
      .bubble      (id_bubble),
      .instr_in    (id_instr),
      .pc_plus4_in (id_pc4),
      .instr       (instr_D),
      .pc_plus4    (D_PCPlus4_D),
      .valid       (valid_D)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// A behavioural model tracks the fetch PC, the IF/ID contents and whether
// a word is parked or an abandoned request is outstanding, and every cycle
// the DUT outputs are compared against it.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  PC_src_D;
   logic [31:0] PCbranch_D;
   logic        stall_FD;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] instr_D;
   logic [31:0] D_PCPlus4_D;
   logic        valid_D;
   logic [31:0] PC_F;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [31:0] m_pc, m_instr, m_pc4, m_buf, m_drain_addr;
   logic        m_valid, m_has_buf, m_draining;

   always #5 clk = ~clk;

   // Instruction memory contents: a scrambled function of the address, so
   // every fetched word identifies where it came from.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .PC_src_D    (PC_src_D),
      .PCbranch_D  (PCbranch_D),
      .stall_FD    (stall_FD),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .instr_D     (instr_D),
      .D_PCPlus4_D (D_PCPlus4_D),
      .valid_D     (valid_D),
      .PC_F        (PC_F)
   );

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Compare all observable outputs against the model.
   task automatic compareAll();
      logic exp_req;
      exp_req = !reset && !m_has_buf;
      checkOutput("PC_F", PC_F, m_pc);
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req)
         checkOutput("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
      checkOutput("instr_D", instr_D, m_instr);
      checkOutput("D_PCPlus4_D", D_PCPlus4_D, m_pc4);
      checkOutput("valid_D", {31'd0, valid_D}, {31'd0, m_valid});
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic modelStep();
      logic [31:0] word, tgt;
      logic        redir;
      word  = mem_word(m_draining ? m_drain_addr : m_pc);
      redir = (PC_src_D != 2'b00) && m_valid && !stall_FD;
      tgt   = PC_src_D[1] ? {m_pc4[31:28], m_instr[25:0], 2'b00} : PCbranch_D;
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_has_buf = 1'b0; m_draining = 1'b0;
      end else if (redir) begin
         m_instr = 32'h0;
         m_valid = 1'b0;
         if (m_has_buf) begin
            m_has_buf = 1'b0;
         end else if (!m_draining && !imem_ready) begin
            m_draining   = 1'b1;
            m_drain_addr = m_pc;
         end
         m_pc = tgt;
      end else if (stall_FD) begin
         if (m_draining) begin
            if (imem_ready) m_draining = 1'b0;
         end else if (!m_has_buf && imem_ready) begin
            m_has_buf = 1'b1;
            m_buf     = word;
         end
      end else if (m_has_buf) begin
         m_instr = m_buf; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
         m_pc = m_pc + 32'd4; m_has_buf = 1'b0;
      end else if (m_draining) begin
         m_instr = 32'h0; m_valid = 1'b0;
         if (imem_ready) m_draining = 1'b0;
      end else if (imem_ready) begin
         m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
         m_pc = m_pc + 32'd4;
      end else begin
         m_instr = 32'h0; m_valid = 1'b0;
      end
   endtask

   // Drive one cycle of inputs according to the test phase.
   task automatic applyStimulus(input int cyc);
      reset      = 1'b0;
      stall_FD   = 1'b0;
      imem_ready = 1'b1;
      PC_src_D   = 2'b00;
      PCbranch_D = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (cyc < 40) begin
         // straight line, then a branch at 0x10, a branch at 0x48 and a jump
         reset = (cyc < 2);
         if (m_valid && m_pc4 == 32'h14) begin
            PC_src_D = 2'b01; PCbranch_D = 32'h40;
         end else if (m_valid && m_pc4 == 32'h4C) begin
            PC_src_D = 2'b01; PCbranch_D = 32'h1000_0000;
         end else if (m_valid && m_pc4 == 32'h1000_0004) begin
            PC_src_D = 2'b11; PCbranch_D = 32'h80;
         end
      end else if (cyc < 100) begin
         imem_ready = (cyc % 3 == 2);
         if ($urandom_range(0, 7) == 0) PC_src_D = 2'($urandom_range(1, 3));
      end else if (cyc < 200) begin
         stall_FD = ((cyc / 6) % 2 == 1) && (cyc % 6 < 4);
         if ($urandom_range(0, 9) == 0) PC_src_D = 2'($urandom_range(1, 3));
      end else begin
         imem_ready = $urandom_range(0, 1) == 1;
         stall_FD   = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 5) == 0) PC_src_D = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) PCbranch_D = 32'hFFFF_FFF8;
         reset = ($urandom_range(0, 99) == 0) || (m_draining && $urandom_range(0, 9) == 0);
      end
   endtask

   initial begin
      reset = 1'b1; stall_FD = 1'b0; imem_ready = 1'b1;
      PC_src_D = 2'b00; PCbranch_D = 32'h0;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_has_buf = 1'b0; m_draining = 1'b0; m_buf = 32'h0; m_drain_addr = 32'h0;
      @(posedge clk);
      for (int cyc = 0; cyc < 2200; cyc++) begin
         @(negedge clk);
         compareAll();
         applyStimulus(cyc);
         modelStep();
      end
      @(negedge clk);
      compareAll();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
